// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 device end of the gsensor link: ADXL345-style 64-byte register file,
// oversampled in the clk_clk domain, with host-side sample streaming and write observation.
module gsensor_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID       = 8'hE5
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        gsensor_SS_n,
    input  logic        gsensor_SCLK,
    input  logic        gsensor_MOSI,
    output logic        gsensor_MISO,
    output logic        gsensor_INT,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic        reg_wr_valid,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        WAIT_DESEL
    } state_t;

    // ---------------- input synchronisers and edge detect ----------------
    logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   ss_prev_q, sclk_prev_q;
    // Counts out the sync chain after reset so WAIT_DESEL only trusts a settled SS_n.
    logic [SYNC_STAGES:0]   settle_q;
    logic                   ss, sclk, mosi, settled;
    logic                   ss_rise, ss_fall, sclk_rise, sclk_fall;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ss_sync_q   <= '1;
            sclk_sync_q <= '1;
            mosi_sync_q <= '0;
            ss_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
            settle_q    <= '0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], gsensor_SS_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], gsensor_SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], gsensor_MOSI};
            ss_prev_q   <= ss;
            sclk_prev_q <= sclk;
            settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign ss        = ss_sync_q[SYNC_STAGES-1];
    assign sclk      = sclk_sync_q[SYNC_STAGES-1];
    assign mosi      = mosi_sync_q[SYNC_STAGES-1];
    assign settled   = settle_q[SYNC_STAGES];
    assign ss_rise   = ss & ~ss_prev_q;
    assign ss_fall   = ~ss & ss_prev_q;
    assign sclk_rise = sclk & ~sclk_prev_q;
    assign sclk_fall = ~sclk & sclk_prev_q;

    // ---------------- register storage ----------------
    logic [7:0]  regs_q [64];
    logic [47:0] smp_q;          // {Z, Y, X}, byte k maps to address 0x32+k
    logic [47:0] pend_smp_q;
    logic        pend_q;
    logic        dr_q;

    // ---------------- frame FSM ----------------
    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [6:0] sh_q, sh_d;
    logic [5:0] addr_q, addr_d;
    logic       mb_q, mb_d;
    logic [7:0] tx_q, tx_d;
    logic       miso_q, miso_d;
    logic       wr_vld_q, wr_vld_d;
    logic [5:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] byte_in;
    logic [5:0] rd_addr;
    logic [7:0] rd_byte;
    logic       rd_load;
    logic [2:0] sidx;

    assign byte_in = {sh_q, mosi};

    // Address of the byte that would be loaded for read on this SCLK rise.
    always_comb begin
        rd_addr = mb_q ? addr_q + 6'd1 : addr_q;
        if (state_q == CMD) rd_addr = byte_in[5:0];
    end

    always_comb begin
        sidx    = 3'(rd_addr - 6'h32);
        rd_byte = regs_q[rd_addr];
        if (rd_addr == 6'h00)
            rd_byte = DEVID;
        else if (rd_addr == 6'h30)
            rd_byte = {dr_q, 7'd0};
        else if (rd_addr >= 6'h32 && rd_addr <= 6'h37)
            rd_byte = smp_q[{sidx, 3'b000} +: 8];
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= WAIT_DESEL;
            bitcnt_q  <= '0;
            sh_q      <= '0;
            addr_q    <= '0;
            mb_q      <= 1'b0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            sh_q      <= sh_d;
            addr_q    <= addr_d;
            mb_q      <= mb_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        sh_d      = sh_q;
        addr_d    = addr_q;
        mb_d      = mb_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d  = CMD;
                    bitcnt_d = '0;
                end
            end
            CMD: begin
                if (sclk_rise) begin
                    sh_d     = byte_in[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        addr_d = byte_in[5:0];
                        mb_d   = byte_in[6];
                        if (byte_in[7]) begin
                            state_d = RDATA;
                            rd_load = 1'b1;
                            tx_d    = rd_byte;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
            end
            WDATA: begin
                if (sclk_rise) begin
                    sh_d     = byte_in[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        wr_vld_d  = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = byte_in;
                        if (mb_q) addr_d = addr_q + 6'd1;
                    end
                end
            end
            RDATA: begin
                if (sclk_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
                if (sclk_rise) begin
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        addr_d  = rd_addr;
                        rd_load = 1'b1;
                        tx_d    = rd_byte;
                    end
                end
            end
            WAIT_DESEL: begin
                if (settled && ss) state_d = IDLE;
            end
            default: state_d = WAIT_DESEL;
        endcase
        // Deselect aborts any partial byte: no write, no read-side effects.
        if (ss_rise && state_q != WAIT_DESEL) begin
            state_d  = IDLE;
            miso_d   = 1'b0;
            wr_vld_d = 1'b0;
            rd_load  = 1'b0;
        end
    end

    // ---------------- register file, sample path, DATA_READY ----------------
    function automatic logic writable(input logic [5:0] a);
        return !(a == 6'h00 || a == 6'h30 || (a >= 6'h32 && a <= 6'h37));
    endfunction

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < 64; i++) regs_q[i] <= '0;
            smp_q      <= '0;
            pend_smp_q <= '0;
            pend_q     <= 1'b0;
            dr_q       <= 1'b0;
        end else begin
            if (wr_vld_q && writable(wr_addr_q))
                regs_q[wr_addr_q] <= wr_data_q;
            if (rd_load && rd_addr >= 6'h32 && rd_addr <= 6'h37)
                dr_q <= 1'b0;
            // Later assignments win: a set in the same cycle overrides the clear above.
            if (sample_valid && ss) begin
                smp_q  <= {sample_z, sample_y, sample_x};
                dr_q   <= 1'b1;
                pend_q <= 1'b0;
            end else if (sample_valid) begin
                pend_smp_q <= {sample_z, sample_y, sample_x};
                pend_q     <= 1'b1;
            end else if (ss_rise && pend_q) begin
                smp_q  <= pend_smp_q;
                dr_q   <= 1'b1;
                pend_q <= 1'b0;
            end
        end
    end

    assign gsensor_MISO = miso_q;
    assign gsensor_INT  = dr_q;
    assign reg_wr_valid = wr_vld_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign busy         = ~ss;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Directed bench for gsensor_spi_responder: bit-banged SPI mode-3 master with per-feature tasks.
module tb_gsensor_spi_responder;

    localparam int HALF = 80;   // SCLK half period: 8 clk_clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss_n = 1'b1;
    logic        sclk = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, gint, wv, bsy;
    logic        sv = 1'b0;
    logic [15:0] sx = '0, sy = '0, sz = '0;
    logic [5:0]  wa;
    logic [7:0]  wd;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    logic [5:0] wa_log [16];
    logic [7:0] wd_log [16];

    gsensor_spi_responder dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .gsensor_SS_n (ss_n),
        .gsensor_SCLK (sclk),
        .gsensor_MOSI (mosi),
        .gsensor_MISO (miso),
        .gsensor_INT  (gint),
        .sample_valid (sv),
        .sample_x     (sx),
        .sample_y     (sy),
        .sample_z     (sz),
        .reg_wr_valid (wv),
        .reg_wr_addr  (wa),
        .reg_wr_data  (wd),
        .busy         (bsy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wv) begin
            wa_log[wr_cnt % 16] = wa;
            wd_log[wr_cnt % 16] = wd;
            wr_cnt++;
        end
    end

    task automatic spi_start();
        @(negedge clk);
        ss_n = 1'b0;
        #HALF;
    endtask

    task automatic spi_end();
        #HALF;
        ss_n = 1'b1;
        #(HALF * 2);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            sclk = 1'b0;
            mosi = tx[i];
            #HALF;
            rx[i] = miso;
            sclk = 1'b1;
            #HALF;
        end
    endtask

    task automatic read1(input logic [7:0] cmd, output logic [7:0] rx);
        logic [7:0] d;
        spi_start();
        spi_byte(cmd, d);
        spi_byte(8'h00, rx);
        spi_end();
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        sx = x; sy = y; sz = z; sv = 1'b1;
        @(negedge clk);
        sv = 1'b0;
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", miso); end
        n_checks++; if (gint !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", gint); end
        n_checks++; if (wv !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", wv); end
        n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bsy); end
        n_checks++; if ({wa, wd} !== 14'h0) begin n_fail++; $display("FAIL reset_wr_bus: got %h want 0", {wa, wd}); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_devid();
        logic [7:0] d, r;
        spi_start();
        spi_byte(8'h80, d);
        n_checks++; if (bsy !== 1'b1) begin n_fail++; $display("FAIL devid_busy: got %b want 1", bsy); end
        spi_byte(8'h00, r);
        spi_end();
        n_checks++; if (r !== 8'hE5) begin n_fail++; $display("FAIL devid_read: got %h want e5", r); end
        n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL devid_busy_end: got %b want 0", bsy); end
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL devid_miso_idle: got %b want 0", miso); end
    endtask

    task automatic test_write();
        logic [7:0] d, r;
        int c0 = wr_cnt;
        spi_start();
        spi_byte(8'h2D, d);
        spi_byte(8'h08, d);
        spi_end();
        n_checks++; if (wr_cnt !== c0 + 1) begin n_fail++; $display("FAIL write_pulses: got %0d want %0d", wr_cnt - c0, 1); end
        n_checks++; if (wa_log[c0 % 16] !== 6'h2D) begin n_fail++; $display("FAIL write_addr: got %h want 2d", wa_log[c0 % 16]); end
        n_checks++; if (wd_log[c0 % 16] !== 8'h08) begin n_fail++; $display("FAIL write_data: got %h want 08", wd_log[c0 % 16]); end
        read1(8'hAD, r);
        n_checks++; if (r !== 8'h08) begin n_fail++; $display("FAIL write_readback: got %h want 08", r); end
    endtask

    task automatic test_ro_write();
        logic [7:0] d, r;
        int c0 = wr_cnt;
        spi_start();
        spi_byte(8'h00, d);
        spi_byte(8'h12, d);
        spi_end();
        n_checks++; if (wr_cnt !== c0 + 1) begin n_fail++; $display("FAIL ro_pulses: got %0d want %0d", wr_cnt - c0, 1); end
        n_checks++; if (wa_log[c0 % 16] !== 6'h00) begin n_fail++; $display("FAIL ro_addr: got %h want 00", wa_log[c0 % 16]); end
        n_checks++; if (wd_log[c0 % 16] !== 8'h12) begin n_fail++; $display("FAIL ro_data: got %h want 12", wd_log[c0 % 16]); end
        read1(8'h80, r);
        n_checks++; if (r !== 8'hE5) begin n_fail++; $display("FAIL ro_devid: got %h want e5", r); end
    endtask

    task automatic test_sample();
        logic [7:0] d, r;
        logic [7:0] exp_b [6] = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h01};
        pulse_sample(16'h1234, 16'hFFFE, 16'h0100);
        repeat (2) @(negedge clk);
        n_checks++; if (gint !== 1'b1) begin n_fail++; $display("FAIL sample_int_set: got %b want 1", gint); end
        spi_start();
        spi_byte(8'hF2, d);
        for (int i = 0; i < 6; i++) begin
            spi_byte(8'h00, r);
            n_checks++; if (r !== exp_b[i]) begin n_fail++; $display("FAIL sample_mb_byte%0d: got %h want %h", i, r, exp_b[i]); end
        end
        spi_end();
        n_checks++; if (gint !== 1'b0) begin n_fail++; $display("FAIL sample_int_clr: got %b want 0", gint); end
    endtask

    task automatic test_back_to_back_pending();
        logic [7:0] d, r;
        logic [7:0] exp_b [6] = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h01};
        pulse_sample(16'h1234, 16'hFFFE, 16'h0100);
        spi_start();
        spi_byte(8'hF2, d);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) pulse_sample(16'hAAAA, 16'hFFFE, 16'h0100);
            spi_byte(8'h00, r);
            n_checks++; if (r !== exp_b[i]) begin n_fail++; $display("FAIL pend_byte%0d: got %h want %h", i, r, exp_b[i]); end
        end
        spi_end();
        n_checks++; if (gint !== 1'b1) begin n_fail++; $display("FAIL pend_int: got %b want 1", gint); end
        read1(8'hB2, r);
        n_checks++; if (r !== 8'hAA) begin n_fail++; $display("FAIL pend_x_lo: got %h want aa", r); end
    endtask

    task automatic test_mb_wrap();
        logic [7:0] d, r;
        int c0 = wr_cnt;
        spi_start();
        spi_byte(8'h7F, d);
        spi_byte(8'h5A, d);
        spi_byte(8'h77, d);
        spi_end();
        n_checks++; if (wr_cnt !== c0 + 2) begin n_fail++; $display("FAIL wrap_pulses: got %0d want %0d", wr_cnt - c0, 2); end
        n_checks++; if (wa_log[c0 % 16] !== 6'h3F) begin n_fail++; $display("FAIL wrap_addr0: got %h want 3f", wa_log[c0 % 16]); end
        n_checks++; if (wa_log[(c0 + 1) % 16] !== 6'h00) begin n_fail++; $display("FAIL wrap_addr1: got %h want 00", wa_log[(c0 + 1) % 16]); end
        n_checks++; if (wd_log[(c0 + 1) % 16] !== 8'h77) begin n_fail++; $display("FAIL wrap_data1: got %h want 77", wd_log[(c0 + 1) % 16]); end
        read1(8'hBF, r);
        n_checks++; if (r !== 8'h5A) begin n_fail++; $display("FAIL wrap_read3f: got %h want 5a", r); end
        read1(8'h80, r);
        n_checks++; if (r !== 8'hE5) begin n_fail++; $display("FAIL wrap_devid: got %h want e5", r); end
    endtask

    task automatic test_abort();
        logic [7:0] d, r;
        int c0 = wr_cnt;
        spi_start();
        spi_byte(8'h2D, d);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b0; mosi = 1'b1; #HALF;
            sclk = 1'b1; #HALF;
        end
        spi_end();
        n_checks++; if (wr_cnt !== c0) begin n_fail++; $display("FAIL abort_pulses: got %0d want 0", wr_cnt - c0); end
        read1(8'hAD, r);
        n_checks++; if (r !== 8'h08) begin n_fail++; $display("FAIL abort_reg_kept: got %h want 08", r); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d, r1, r2, r;
        int c0;
        spi_start();
        spi_byte(8'h2D, d);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        c0 = wr_cnt;
        spi_byte(8'h80, r1);
        spi_byte(8'h00, r2);
        spi_end();
        n_checks++; if (wr_cnt !== c0) begin n_fail++; $display("FAIL rstmid_pulses: got %0d want 0", wr_cnt - c0); end
        n_checks++; if ({r1, r2} !== 16'h0000) begin n_fail++; $display("FAIL rstmid_miso: got %h want 0000", {r1, r2}); end
        n_checks++; if (gint !== 1'b0) begin n_fail++; $display("FAIL rstmid_int: got %b want 0", gint); end
        read1(8'hAD, r);
        n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL rstmid_reg_cleared: got %h want 00", r); end
        read1(8'h80, r);
        n_checks++; if (r !== 8'hE5) begin n_fail++; $display("FAIL rstmid_recover: got %h want e5", r); end
    endtask

    initial begin
        test_reset();
        test_devid();
        test_write();
        test_ro_write();
        test_sample();
        test_back_to_back_pending();
        test_mb_wrap();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, limit 2000000");
        $fatal(1);
    end

endmodule
